// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern scheduler: state encoding and defaults.
package led_pkg;

    localparam int LED_W_DEF = 18;
    localparam logic [LED_W_DEF-1:0] LED_OFF = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HANDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/led_next_sel.sv
// Finds the next set mask bit strictly after index cur, wrapping modulo N.
// With cur = N-1 this yields the lowest set bit.
module led_next_sel #(
    parameter int N = 5
) (
    input  logic [N-1:0] mask,
    input  logic [2:0]   cur,
    output logic [2:0]   nxt,
    output logic         none
);

    logic [2:0] idx;

    // Scan from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        nxt  = 3'd0;
        none = 1'b1;
        idx  = 3'd0;
        for (int k = N; k >= 1; k--) begin
            idx = 3'((int'(cur) + k) % N);
            if (mask[idx]) begin
                nxt  = idx;
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Round-robin scheduler for the LED pattern blocks with registered LED mux.
// Optional stuck-block watchdog enabled by defining LED_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | no grant, LED off; waits for enabler and a non-empty mask
// RUN     | cur_st granted; counting st_over rising edges up to REPEAT
// HANDOFF | single cycle with grant dropped; selects next masked block
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int NUM_ST   = 5,
    parameter int LED_W    = LED_W_DEF,
    parameter int REPEAT   = 2,
    parameter int WDOG_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rs,
    input  logic                    enabler,
    input  logic [NUM_ST-1:0]       st_mask,
    input  logic [NUM_ST-1:0]       st_over,
    input  logic [NUM_ST*LED_W-1:0] st_out,
    output logic [NUM_ST-1:0]       st_begin,
    output logic                    st_en,
    output logic [LED_W-1:0]        out,
    output logic [2:0]              cur_st,
    output logic                    wdog_err
);

    state_t     state;
    logic [3:0] rep_cnt;
    logic       over_d;
    logic [2:0] sel_from;
    logic [2:0] sel_nxt;
    logic       sel_none;
    logic       over_cur;
    logic       rise;

    assign st_en    = enabler;
    assign over_cur = st_over[cur_st];
    assign rise     = over_cur & ~over_d;
    // Searching after NUM_ST-1 in IDLE gives the lowest set bit.
    assign sel_from = (state == IDLE) ? 3'(NUM_ST - 1) : cur_st;

    led_next_sel #(.N(NUM_ST)) u_next_sel (
        .mask (st_mask),
        .cur  (sel_from),
        .nxt  (sel_nxt),
        .none (sel_none)
    );

`ifdef LED_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC);
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_err_q;
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rs) begin
            state    <= IDLE;
            cur_st   <= 3'd0;
            st_begin <= '0;
            out      <= LED_W'(LED_OFF);
            rep_cnt  <= 4'd0;
            over_d   <= 1'b0;
`ifdef LED_SEQ_WATCHDOG_EN
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
`ifdef LED_SEQ_WATCHDOG_EN
            wdog_err_q <= 1'b0;
`endif
            if (!enabler) begin
                state    <= IDLE;
                st_begin <= '0;
                out      <= LED_W'(LED_OFF);
                rep_cnt  <= 4'd0;
                over_d   <= 1'b0;
`ifdef LED_SEQ_WATCHDOG_EN
                wdog_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        st_begin <= '0;
                        out      <= LED_W'(LED_OFF);
                        rep_cnt  <= 4'd0;
                        over_d   <= 1'b0;
`ifdef LED_SEQ_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (!sel_none) begin
                            cur_st <= sel_nxt;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        st_begin <= NUM_ST'(1) << cur_st;
                        out      <= st_out[int'(cur_st)*LED_W +: LED_W];
                        over_d   <= over_cur;
                        if (rise) begin
`ifdef LED_SEQ_WATCHDOG_EN
                            wdog_cnt <= '0;
`endif
                            if (rep_cnt == 4'(REPEAT - 1)) begin
                                rep_cnt <= 4'd0;
                                state   <= HANDOFF;
                            end else begin
                                rep_cnt <= rep_cnt + 4'd1;
                            end
                        end
`ifdef LED_SEQ_WATCHDOG_EN
                        else if (wdog_cnt == WDOG_W'(WDOG_CYC - 1)) begin
                            wdog_cnt   <= '0;
                            wdog_err_q <= 1'b1;
                            rep_cnt    <= 4'd0;
                            state      <= HANDOFF;
                        end else begin
                            wdog_cnt <= wdog_cnt + 1'b1;
                        end
`endif
                    end
                    HANDOFF: begin
                        // Dropping the grant lets the outgoing block recycle; out holds.
                        st_begin <= '0;
                        over_d   <= 1'b0;
`ifdef LED_SEQ_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (sel_none) begin
                            state <= IDLE;
                        end else begin
                            cur_st <= sel_nxt;
                            state  <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: vector table, directed corner sequences,
// then randomized stimulus against a behavioural scheduler model.
`timescale 1ns/1ps
module tb_led_seq_ctrl;

    localparam int NUM_ST   = 5;
    localparam int LED_W    = 18;
    localparam int REPEAT   = 2;
    localparam int WDOG_CYC = 16;
`ifdef LED_SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rs;
    logic                    enabler;
    logic [NUM_ST-1:0]       st_mask;
    logic [NUM_ST-1:0]       st_over;
    logic [NUM_ST*LED_W-1:0] st_out;
    logic [NUM_ST-1:0]       st_begin;
    logic                    st_en;
    logic [LED_W-1:0]        out;
    logic [2:0]              cur_st;
    logic                    wdog_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .NUM_ST(NUM_ST), .LED_W(LED_W), .REPEAT(REPEAT), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk(clk), .rs(rs), .enabler(enabler), .st_mask(st_mask), .st_over(st_over),
        .st_out(st_out), .st_begin(st_begin), .st_en(st_en), .out(out),
        .cur_st(cur_st), .wdog_err(wdog_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rs = 1'b1; enabler = 1'b0; st_over = '0; st_out = '0; st_mask = '0;
        tick(); tick();
        rs = 1'b0;
    endtask

    task automatic wait_begin(input int idx, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            if (st_begin == 5'(1 << idx)) hit = 1'b1;
            else tick();
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic run_block(input int idx);
        wait_begin(idx, "grant_order");
        check("grant_cur", 32'(cur_st), 32'(idx));
        check("grant_in_mask", 32'(st_begin & ~st_mask), 32'd0);
        for (int r = 0; r < REPEAT; r++) begin
            st_over = 5'($urandom_range(0, 31)); st_over[idx] = 1'b1; tick();
            st_over = 5'($urandom_range(0, 31)); st_over[idx] = 1'b0; tick();
        end
        st_over = '0;
    endtask

    // Behavioural model: phase 0 = off, 1 = block granted, 2 = gap cycle.
    int               m_phase, m_cur, m_reps, m_quiet;
    bit               m_prev, m_err;
    logic [4:0]       m_beg;
    logic [LED_W-1:0] m_out;

    function automatic int first_after(input logic [4:0] mask, input int from);
        for (int k = 1; k <= NUM_ST; k++)
            if (mask[(from + k) % NUM_ST]) return (from + k) % NUM_ST;
        return -1;
    endfunction

    task automatic model_step();
        bit lvl;
        if (rs) begin
            m_phase = 0; m_cur = 0; m_beg = '0; m_out = '0;
            m_reps = 0; m_prev = 0; m_quiet = 0; m_err = 0;
        end else if (!enabler) begin
            m_phase = 0; m_beg = '0; m_out = '0;
            m_reps = 0; m_prev = 0; m_quiet = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (m_phase == 0) begin
                m_beg = '0; m_out = '0; m_reps = 0; m_prev = 0; m_quiet = 0;
                if (st_mask != 0) begin
                    m_cur = first_after(st_mask, NUM_ST - 1);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                lvl   = st_over[m_cur];
                m_beg = 5'(1 << m_cur);
                m_out = st_out[m_cur*LED_W +: LED_W];
                if (lvl && !m_prev) begin
                    m_quiet = 0;
                    m_reps++;
                    if (m_reps == REPEAT) begin m_reps = 0; m_phase = 2; end
                end else if (WD_ON && m_quiet == WDOG_CYC - 1) begin
                    m_quiet = 0; m_reps = 0; m_err = 1; m_phase = 2;
                end else if (WD_ON) begin
                    m_quiet++;
                end
                m_prev = lvl;
            end else begin
                m_beg = '0; m_prev = 0; m_quiet = 0;
                if (st_mask == 0) m_phase = 0;
                else begin
                    m_cur = first_after(st_mask, m_cur);
                    m_phase = 1;
                end
            end
        end
    endtask

    typedef struct {
        logic       en;
        logic [4:0] mask;
        logic [4:0] over;
        logic [4:0] exp_begin;
        logic [2:0] exp_cur;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int errs_seen;
        bit hit;

        tbl[0]  = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 3'd0};
        tbl[1]  = '{1'b1, 5'b11111, 5'b00000, 5'b00001, 3'd0};
        tbl[2]  = '{1'b1, 5'b11111, 5'b00001, 5'b00001, 3'd0};
        tbl[3]  = '{1'b1, 5'b11111, 5'b00001, 5'b00001, 3'd0};
        tbl[4]  = '{1'b1, 5'b11111, 5'b00000, 5'b00001, 3'd0};
        tbl[5]  = '{1'b1, 5'b11111, 5'b00001, 5'b00001, 3'd0};
        tbl[6]  = '{1'b1, 5'b11111, 5'b00001, 5'b00000, 3'd1};
        tbl[7]  = '{1'b1, 5'b11111, 5'b00000, 5'b00010, 3'd1};
        tbl[8]  = '{1'b1, 5'b11111, 5'b11101, 5'b00010, 3'd1};
        tbl[9]  = '{1'b1, 5'b11111, 5'b11101, 5'b00010, 3'd1};
        tbl[10] = '{1'b1, 5'b11111, 5'b00010, 5'b00010, 3'd1};
        tbl[11] = '{1'b1, 5'b11111, 5'b00000, 5'b00010, 3'd1};
        tbl[12] = '{1'b1, 5'b11111, 5'b00010, 5'b00010, 3'd1};
        tbl[13] = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 3'd2};
        tbl[14] = '{1'b1, 5'b11111, 5'b00000, 5'b00100, 3'd2};

        do_reset();
        check("rst_begin", 32'(st_begin), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_cur", 32'(cur_st), 32'd0);
        check("rst_wdog", 32'(wdog_err), 32'd0);

        for (int i = 0; i < 15; i++) begin
            enabler = tbl[i].en; st_mask = tbl[i].mask; st_over = tbl[i].over;
            tick();
            check($sformatf("tbl%0d_begin", i), 32'(st_begin), 32'(tbl[i].exp_begin));
            check($sformatf("tbl%0d_cur", i), 32'(cur_st), 32'(tbl[i].exp_cur));
        end

        // Sparse mask: rotation 2,4,2,4 with noise on the non-granted flags.
        do_reset();
        enabler = 1'b1; st_mask = 5'b10100;
        run_block(2); run_block(4); run_block(2); run_block(4);
        wait_begin(2, "wrap_to_2");
        st_out[2*LED_W +: LED_W] = 18'h3FFFF;
        tick();
        check("out_mux", 32'(out), 32'h3FFFF);
        enabler = 1'b0;
        tick();
        check("dis_out", 32'(out), 32'd0);
        check("dis_begin", 32'(st_begin), 32'd0);
        enabler = 1'b1;
        tick();
        check("reen_gap", 32'(st_begin), 32'd0);
        tick();
        check("reen_begin", 32'(st_begin), 32'b00100);
        check("reen_cur", 32'(cur_st), 32'd2);

        // A flag held high is a single edge.
        st_over = 5'b00100;
        for (int i = 0; i < 20; i++) tick();
        check("hold_no_handoff", 32'(st_begin), 32'b00100);
        st_over = '0; tick();
        st_over = 5'b00100; tick();
        st_over = '0; tick();
        check("hold_gap_begin", 32'(st_begin), 32'd0);
        check("hold_gap_cur", 32'(cur_st), 32'd4);
        tick();
        check("hold_next_begin", 32'(st_begin), 32'b10000);

`ifdef LED_SEQ_WATCHDOG_EN
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (wdog_err) hit = 1'b1;
        end
        check("wdog_fired", 32'(hit), 32'd1);
        check("wdog_cur", 32'(cur_st), 32'd4);
        tick();
        check("wdog_pulse_width", 32'(wdog_err), 32'd0);
        check("wdog_forced_next", 32'(cur_st), 32'd2);
`else
        errs_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wdog_err !== 1'b0) errs_seen++;
        end
        check("wdog_tied_low", 32'(errs_seen), 32'd0);
        check("stuck_holds_grant", 32'(st_begin), 32'b10000);
`endif

        // Reset mid-RUN on block 3.
        do_reset();
        st_mask = 5'b01000; enabler = 1'b1;
        tick(); tick();
        check("mid_cur", 32'(cur_st), 32'd3);
        check("mid_begin", 32'(st_begin), 32'b01000);
        st_out[3*LED_W +: LED_W] = 18'h2A5A5;
        tick();
        check("mid_out", 32'(out), 32'h2A5A5);
        rs = 1'b1;
        tick();
        check("rs_begin", 32'(st_begin), 32'd0);
        check("rs_out", 32'(out), 32'd0);
        check("rs_cur", 32'(cur_st), 32'd0);
        check("rs_wdog", 32'(wdog_err), 32'd0);
        rs = 1'b0;

        // Randomized run against the model, starting from a clean reset.
        rs = 1'b1; enabler = 1'b0; st_over = '0; st_mask = '0; st_out = '0;
        @(posedge clk); model_step(); #1;
        for (int c = 0; c < 3000; c++) begin
            rs      = ($urandom_range(0, 299) == 0);
            enabler = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 19) == 0) st_mask = 5'($urandom_range(0, 31));
            for (int b = 0; b < NUM_ST; b++)
                if ($urandom_range(0, 3) == 0) st_over[b] = ~st_over[b];
            st_out = (NUM_ST*LED_W)'({$urandom(), $urandom(), $urandom()});
            @(posedge clk);
            model_step();
            #1;
            check("rnd_begin", 32'(st_begin), 32'(m_beg));
            check("rnd_out", 32'(out), 32'(m_out));
            check("rnd_cur", 32'(cur_st), 32'(m_cur));
            check("rnd_wdog", 32'(wdog_err), 32'(m_err));
            check("rnd_st_en", 32'(st_en), 32'(enabler));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
